// File: rtl/id_stage.sv
// Instruction decode stage: 32x32 register file with writeback bypass, RV32 subset
// decode (LW/SW/OP-IMM/OP), load-use hazard detection and the ID/EX pipeline register.
module id_stage (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        IFIDvalid,
  input  logic [31:0] IFIDIR,
  input  logic [31:0] IFIDPC,
  input  logic        flush,
  input  logic        exstall,
  input  logic        MEMWBRegWrite,
  input  logic [4:0]  MEMWBrd,
  input  logic [31:0] MEMWBValue,
  output logic        IDEXvalid,
  output logic        IDEXRegWrite,
  output logic        IDEXMemRead,
  output logic        IDEXMemWrite,
  output logic [6:0]  IDEXop,
  output logic [2:0]  IDEXfunct3,
  output logic [6:0]  IDEXfunct7,
  output logic [4:0]  IDEXrd,
  output logic [31:0] IDEXAin,
  output logic [31:0] IDEXBin,
  output logic [31:0] IDEXStoreData,
  output logic [31:0] IDEXPC,
  output logic        IFIDstall,
  output logic        illegal
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_ALUI = 7'b0010011;
  localparam logic [6:0] OP_ALUR = 7'b0110011;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] ain;
    logic [31:0] bin;
    logic [31:0] store_data;
    logic [31:0] pc;
  } idex_t;

  idex_t       idex_q, idex_d, dec;
  logic        illegal_q, illegal_d;
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  logic [6:0]  op;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rs1_val, rs2_val, imm_i, imm_s;
  logic        supported, hazard;

  assign op    = IFIDIR[6:0];
  assign rd    = IFIDIR[11:7];
  assign rs1   = IFIDIR[19:15];
  assign rs2   = IFIDIR[24:20];
  assign imm_i = {{20{IFIDIR[31]}}, IFIDIR[31:20]};
  assign imm_s = {{20{IFIDIR[31]}}, IFIDIR[31:25], IFIDIR[11:7]};

  // Reads see a same-cycle writeback; x0 overrides everything.
  always_comb begin
    rs1_val = regs_q[rs1];
    if (MEMWBRegWrite && (MEMWBrd == rs1)) rs1_val = MEMWBValue;
    if (rs1 == 5'd0) rs1_val = '0;
    rs2_val = regs_q[rs2];
    if (MEMWBRegWrite && (MEMWBrd == rs2)) rs2_val = MEMWBValue;
    if (rs2 == 5'd0) rs2_val = '0;
  end

  always_comb begin
    regs_d = regs_q;
    if (MEMWBRegWrite && (MEMWBrd != 5'd0)) regs_d[MEMWBrd] = MEMWBValue;
  end

  always_comb begin
    dec        = '0;
    dec.valid  = 1'b1;
    dec.op     = op;
    dec.funct3 = IFIDIR[14:12];
    dec.pc     = IFIDPC;
    dec.ain    = rs1_val;
    supported  = 1'b1;
    case (op)
      OP_LW: begin
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
        dec.rd        = rd;
        dec.bin       = imm_i;
      end
      OP_SW: begin
        dec.mem_write  = 1'b1;
        dec.bin        = imm_s;
        dec.store_data = rs2_val;
      end
      OP_ALUI: begin
        dec.reg_write = 1'b1;
        dec.rd        = rd;
        dec.bin       = imm_i;
      end
      OP_ALUR: begin
        dec.reg_write = 1'b1;
        dec.rd        = rd;
        dec.funct7    = IFIDIR[31:25];
        dec.bin       = rs2_val;
      end
      default: supported = 1'b0;
    endcase
  end

  // Load in EX whose destination is a source of the instruction in ID.
  assign hazard = idex_q.valid && idex_q.mem_read && (idex_q.rd != 5'd0) && IFIDvalid &&
                  ((idex_q.rd == rs1) ||
                   ((idex_q.rd == rs2) && ((op == OP_SW) || (op == OP_ALUR))));

  // Handshake: while IFIDstall is high fetch holds IFIDIR/IFIDPC/IFIDvalid unchanged;
  // the instruction is consumed on the first rising edge with IFIDstall low.
  assign IFIDstall = (hazard || exstall) && !flush;

  always_comb begin
    idex_d    = idex_q;
    illegal_d = 1'b0;
    if (flush) begin
      idex_d = '0;
    end else if (exstall) begin
      idex_d = idex_q;
    end else if (hazard || !IFIDvalid) begin
      idex_d = '0;
    end else if (!supported) begin
      idex_d    = '0;
      illegal_d = 1'b1;
    end else begin
      idex_d = dec;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idex_q    <= '0;
      illegal_q <= 1'b0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      idex_q    <= idex_d;
      illegal_q <= illegal_d;
      regs_q    <= regs_d;
    end
  end

  assign IDEXvalid     = idex_q.valid;
  assign IDEXRegWrite  = idex_q.reg_write;
  assign IDEXMemRead   = idex_q.mem_read;
  assign IDEXMemWrite  = idex_q.mem_write;
  assign IDEXop        = idex_q.op;
  assign IDEXfunct3    = idex_q.funct3;
  assign IDEXfunct7    = idex_q.funct7;
  assign IDEXrd        = idex_q.rd;
  assign IDEXAin       = idex_q.ain;
  assign IDEXBin       = idex_q.bin;
  assign IDEXStoreData = idex_q.store_data;
  assign IDEXPC        = idex_q.pc;
  assign illegal       = illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios followed by random traffic, all checked
// against an architectural model of the decode stage kept in the bench.
module tb_id_stage;

  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_R  = 7'b0110011;

  typedef struct packed {
    logic        v, rw, mr, mw;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [31:0] a, b, sd, pc;
  } st_t;

  // clock / reset
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic        IFIDvalid, flush, exstall, MEMWBRegWrite;
  logic [31:0] IFIDIR, IFIDPC, MEMWBValue;
  logic [4:0]  MEMWBrd;
  logic        IDEXvalid, IDEXRegWrite, IDEXMemRead, IDEXMemWrite, IFIDstall, illegal;
  logic [6:0]  IDEXop, IDEXfunct7;
  logic [2:0]  IDEXfunct3;
  logic [4:0]  IDEXrd;
  logic [31:0] IDEXAin, IDEXBin, IDEXStoreData, IDEXPC;

  id_stage dut (
    .clock(clock), .reset_n(reset_n), .IFIDvalid(IFIDvalid), .IFIDIR(IFIDIR),
    .IFIDPC(IFIDPC), .flush(flush), .exstall(exstall), .MEMWBRegWrite(MEMWBRegWrite),
    .MEMWBrd(MEMWBrd), .MEMWBValue(MEMWBValue), .IDEXvalid(IDEXvalid),
    .IDEXRegWrite(IDEXRegWrite), .IDEXMemRead(IDEXMemRead), .IDEXMemWrite(IDEXMemWrite),
    .IDEXop(IDEXop), .IDEXfunct3(IDEXfunct3), .IDEXfunct7(IDEXfunct7), .IDEXrd(IDEXrd),
    .IDEXAin(IDEXAin), .IDEXBin(IDEXBin), .IDEXStoreData(IDEXStoreData), .IDEXPC(IDEXPC),
    .IFIDstall(IFIDstall), .illegal(illegal)
  );

  // reference model state
  st_t         cur;
  bit          cur_ill;
  logic [31:0] mrf [32];
  int          n_chk = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sx(input logic [11:0] x);
    return 32'($signed(x));
  endfunction

  function automatic logic [31:0] rdv(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (MEMWBRegWrite && MEMWBrd == idx) return MEMWBValue;
    return mrf[idx];
  endfunction

  function automatic bit is_sup(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_I) || (op == OP_R);
  endfunction

  // What a supported instruction should put into ID/EX.
  function automatic st_t mdec(input logic [31:0] ir, input logic [31:0] pc);
    st_t d = '0;
    logic [4:0] rs1 = ir[19:15];
    logic [4:0] rs2 = ir[24:20];
    logic [11:0] ii = ir[31:20];
    logic [11:0] si = {ir[31:25], ir[11:7]};
    d.v = 1; d.op = ir[6:0]; d.f3 = ir[14:12]; d.pc = pc; d.a = rdv(rs1);
    if (ir[6:0] == OP_LW) begin d.rw = 1; d.mr = 1; d.rd = ir[11:7]; d.b = sx(ii); end
    if (ir[6:0] == OP_I)  begin d.rw = 1; d.rd = ir[11:7]; d.b = sx(ii); end
    if (ir[6:0] == OP_SW) begin d.mw = 1; d.b = sx(si); d.sd = rdv(rs2); end
    if (ir[6:0] == OP_R)  begin d.rw = 1; d.rd = ir[11:7]; d.f7 = ir[31:25]; d.b = rdv(rs2); end
    return d;
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OP_R};
  endfunction

  function automatic logic [31:0] enc_s(input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OP_SW};
  endfunction

  // driver
  task automatic drive(input bit v, input logic [31:0] ir, input logic [31:0] pc,
                       input bit fl, input bit ex, input bit we, input logic [4:0] wrd,
                       input logic [31:0] wv);
    IFIDvalid = v; IFIDIR = ir; IFIDPC = pc; flush = fl; exstall = ex;
    MEMWBRegWrite = we; MEMWBrd = wrd; MEMWBValue = wv;
  endtask

  task automatic chk_out(input string tag);
    chk({tag, ".valid"}, IDEXvalid, cur.v);
    chk({tag, ".regwrite"}, IDEXRegWrite, cur.rw);
    chk({tag, ".memread"}, IDEXMemRead, cur.mr);
    chk({tag, ".memwrite"}, IDEXMemWrite, cur.mw);
    chk({tag, ".op"}, IDEXop, cur.op);
    chk({tag, ".funct3"}, IDEXfunct3, cur.f3);
    chk({tag, ".funct7"}, IDEXfunct7, cur.f7);
    chk({tag, ".rd"}, IDEXrd, cur.rd);
    chk({tag, ".ain"}, IDEXAin, cur.a);
    chk({tag, ".bin"}, IDEXBin, cur.b);
    chk({tag, ".store"}, IDEXStoreData, cur.sd);
    chk({tag, ".pc"}, IDEXPC, cur.pc);
    chk({tag, ".illegal"}, illegal, cur_ill);
  endtask

  function automatic bit m_hazard();
    logic [6:0] op = IFIDIR[6:0];
    return cur.v && cur.mr && cur.rd != 0 && IFIDvalid &&
           (cur.rd == IFIDIR[19:15] ||
            (cur.rd == IFIDIR[24:20] && (op == OP_SW || op == OP_R)));
  endfunction

  // One clock: check the stall mid-cycle, advance the model, check ID/EX after the edge.
  task automatic cyc(input string tag);
    st_t nxt;
    bit  nill;
    @(negedge clock);
    chk({tag, ".ifidstall"}, IFIDstall, (m_hazard() || exstall) && !flush);
    nill = 0;
    if (flush) nxt = '0;
    else if (exstall) nxt = cur;
    else if (m_hazard() || !IFIDvalid) nxt = '0;
    else if (!is_sup(IFIDIR[6:0])) begin nxt = '0; nill = 1; end
    else nxt = mdec(IFIDIR, IFIDPC);
    @(posedge clock);
    cur = nxt;
    cur_ill = nill;
    if (MEMWBRegWrite && MEMWBrd != 0) mrf[MEMWBrd] = MEMWBValue;
    #1;
    chk_out(tag);
  endtask

  task automatic model_reset();
    cur = '0;
    cur_ill = 0;
    for (int i = 0; i < 32; i++) mrf[i] = '0;
  endtask

  logic [6:0] bad_ops [4] = '{7'b1100011, 7'b1101111, 7'b0110111, 7'b0000000};

  initial begin
    st_t snap;
    logic [31:0] ir;
    logic [4:0]  ra, rb, rc;

    // reset
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    chk_out("reset");
    chk("reset.ifidstall", IFIDstall, 0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // ADDI x6,x5,-3 after x5=7 via writeback
    drive(0, 0, 0, 0, 0, 1, 5, 32'd7);
    cyc("wb_x5");
    drive(1, enc_i(OP_I, 6, 0, 5, 12'hFFD), 32'h100, 0, 0, 0, 0, 0);
    cyc("addi");
    chk("addi.ain_c", IDEXAin, 32'd7);
    chk("addi.bin_c", IDEXBin, 32'hFFFF_FFFD);
    chk("addi.rd_c", IDEXrd, 6);
    chk("addi.op_c", IDEXop, 7'b0010011);

    // LW x3,8(x1) then dependent ADD x4,x3,x2: one bubble, then ADD
    drive(0, 0, 0, 0, 0, 1, 1, 32'h40);
    cyc("wb_x1");
    drive(1, enc_i(OP_LW, 3, 3'b010, 1, 12'd8), 32'h104, 0, 0, 1, 2, 32'h11);
    cyc("lw");
    drive(1, enc_r(7'h00, 2, 3, 3'b000, 4), 32'h108, 0, 0, 0, 0, 0);
    cyc("lu_bubble");
    chk("lu_bubble.valid_c", IDEXvalid, 0);
    cyc("lu_add");
    chk("lu_add.valid_c", IDEXvalid, 1);
    chk("lu_add.f7_c", IDEXfunct7, 0);
    chk("lu_add.rd_c", IDEXrd, 4);

    // SW x2,-4(x1) with x2=0xAB
    drive(0, 0, 0, 0, 0, 1, 2, 32'hAB);
    cyc("wb_x2");
    drive(1, enc_s(2, 1, 3'b010, 12'hFFC), 32'h10C, 0, 0, 0, 0, 0);
    cyc("sw");
    chk("sw.bin_c", IDEXBin, 32'hFFFF_FFFC);
    chk("sw.store_c", IDEXStoreData, 32'hAB);
    chk("sw.memwrite_c", IDEXMemWrite, 1);

    // SUB x1,x9,x9 with same-cycle writeback of x9
    drive(1, enc_r(7'h20, 9, 9, 3'b000, 1), 32'h110, 0, 0, 1, 9, 32'h55);
    cyc("sub_bypass");
    chk("sub_bypass.ain_c", IDEXAin, 32'h55);
    chk("sub_bypass.bin_c", IDEXBin, 32'h55);
    chk("sub_bypass.f7_c", IDEXfunct7, 7'h20);

    // unsupported opcode: pulse, then quiet under flush
    drive(1, 32'h0000_0063, 32'h114, 0, 0, 0, 0, 0);
    cyc("illegal");
    chk("illegal.pulse_c", illegal, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cyc("illegal_end");
    drive(1, 32'h0000_0063, 32'h118, 1, 0, 0, 0, 0);
    cyc("illegal_flush");
    chk("illegal_flush.pulse_c", illegal, 0);

    // exstall held for three cycles
    drive(1, enc_i(OP_I, 7, 3'b100, 9, 12'h123), 32'h11C, 0, 0, 0, 0, 0);
    cyc("pre_stall");
    snap = cur;
    for (int i = 0; i < 3; i++) begin
      drive(1, enc_r(7'h00, 1, 2, 3'b001, 8), 32'h120 + i, 0, 1, 0, 0, 0);
      cyc("exstall");
      chk("exstall.ain_hold", IDEXAin, snap.a);
      chk("exstall.pc_hold", IDEXPC, snap.pc);
    end

    // reset mid-hazard
    drive(1, enc_i(OP_LW, 3, 3'b010, 1, 12'd0), 32'h200, 0, 0, 0, 0, 0);
    cyc("lw2");
    drive(1, enc_r(7'h00, 2, 3, 3'b000, 4), 32'h204, 0, 0, 0, 0, 0);
    @(negedge clock);
    chk("midhaz.ifidstall", IFIDstall, 1);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk_out("midrst");
    chk("midrst.ifidstall", IFIDstall, 0);
    @(posedge clock);
    #1;
    chk_out("midrst_hold");
    drive(1, enc_i(OP_I, 6, 0, 5, 12'd1), 32'h208, 0, 0, 0, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    cyc("post_rst");
    chk("post_rst.ain_c", IDEXAin, 32'd0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      ra = 5'($urandom_range(0, 7));
      rb = 5'($urandom_range(0, 7));
      rc = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: ir = enc_i(OP_LW, rc, 3'($urandom), ra, 12'($urandom));
        1: ir = enc_s(rb, ra, 3'($urandom), 12'($urandom));
        2: ir = enc_i(OP_I, rc, 3'($urandom), ra, 12'($urandom));
        3: ir = enc_r(7'($urandom), rb, ra, 3'($urandom), rc);
        4: ir = {25'($urandom), bad_ops[$urandom_range(0, 3)]};
        default: ir = $urandom;
      endcase
      drive($urandom_range(0, 7) != 0, ir, $urandom, $urandom_range(0, 9) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 7)), $urandom);
      cyc("rand");
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 The block SHALL have exactly one clock and one reset, with ports as listed below (clock and reset first).
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 IFIDvalid  input  1  IFIDIR/IFIDPC hold a real instruction.
REQ-005 IFIDIR  input  32  instruction word from fetch.
REQ-006 IFIDPC  input  32  PC of IFIDIR.
REQ-007 flush  input  1  squash the instruction being decoded.
REQ-008 exstall  input  1  EX cannot accept; hold ID/EX register.
REQ-009 MEMWBRegWrite  input  1  writeback enable.
REQ-010 MEMWBrd  input  5  writeback destination register.
REQ-011 MEMWBValue  input  32  writeback data.
REQ-012 IDEXvalid, IDEXRegWrite, IDEXMemRead, IDEXMemWrite  output  1 each  ID/EX valid and control bits.
REQ-013 IDEXop (7), IDEXfunct3 (3), IDEXfunct7 (7), IDEXrd (5)  output  decoded fields consumed by the ALU and later stages.
REQ-014 IDEXAin, IDEXBin, IDEXStoreData, IDEXPC  output  32 each  ALU operands, store data, PC.
REQ-015 IFIDstall  output  1  combinational; fetch SHALL hold IFID while high.
REQ-016 illegal  output  1  registered one-cycle pulse for an unsupported opcode.

Function
REQ-017 Supported opcodes SHALL be LW=0000011, SW=0100011, ALUopI=0010011 and ALUopR=0110011; fields are rs1=[19:15], rs2=[24:20], rd=[11:7], funct3=[14:12], funct7=[31:25].
REQ-018 The register file SHALL hold 32x32 bits, with x0 reading 0 and writes to x0 ignored.
REQ-019 A write on MEMWBRegWrite with MEMWBrd equal to a register read in the same cycle SHALL bypass MEMWBValue to that read.
REQ-020 Immediates SHALL be sign-extended: I-type from [31:20] for LW and ALUopI; S-type from {[31:25],[11:7]} for SW.
REQ-021 Operand outputs: IDEXAin = rs1 value; IDEXBin = immediate for LW/SW/ALUopI and rs2 value for ALUopR; IDEXStoreData = rs2 value for SW, otherwise 0.
REQ-022 Control outputs: IDEXRegWrite=1 for LW/ALUopI/ALUopR; IDEXMemRead=1 for LW only; IDEXMemWrite=1 for SW only.
REQ-023 IDEXrd SHALL be 0 for SW; IDEXfunct7 SHALL be 0 for all non-R opcodes; funct3 and funct7 combinations SHALL pass through unchecked.
REQ-024 Load-use hazard = IDEXvalid & IDEXMemRead & IDEXrd!=0 & IFIDvalid & (IDEXrd==rs1 | (IDEXrd==rs2 & op in {SW, ALUopR})).
REQ-025 IFIDstall = (hazard & !flush) | (exstall & !flush).
REQ-026 Per-edge priority for the ID/EX register SHALL be: reset > flush (load bubble) > exstall (hold all outputs) > hazard (load bubble) > load decoded instruction.
REQ-027 Bubble SHALL mean all ID/EX outputs are 0, including IDEXvalid.
REQ-028 IFIDvalid=0 SHALL load a bubble.
REQ-029 A valid unsupported opcode SHALL load a bubble and pulse illegal high for exactly the following cycle; illegal SHALL NOT pulse under flush, exstall or hazard.
REQ-030 Register-file writes SHALL proceed regardless of flush, exstall or hazard.
REQ-031 Decode-to-output latency SHALL be one cycle; a hazard SHALL delay the dependent instruction by exactly one bubble.

Reset
REQ-032 While reset_n=0, all ID/EX outputs, illegal and all 32 registers SHALL be 0, taking effect immediately (asynchronously).
REQ-033 After reset_n rises, the first rising edge SHALL decode normally.
REQ-034 Reset asserted mid-hazard SHALL discard the pending stall.

Verification
REQ-035 Load x5=7 through writeback, then decode ADDI x6,x5,-3 -> next cycle IDEXop=0010011, IDEXAin=7, IDEXBin=FFFFFFFD, IDEXrd=6, IDEXRegWrite=1.
REQ-036 LW x3,8(x1) followed by ADD x4,x3,x2 -> IFIDstall=1 for one cycle, one bubble issued, then the ADD is issued with funct7=0000000 and funct3=000.
REQ-037 SW x2,-4(x1) with x2=0xAB -> IDEXBin=FFFFFFFC, IDEXStoreData=000000AB, IDEXrd=0, IDEXMemWrite=1.
REQ-038 Same-cycle writeback of x9=0x55 while decoding SUB x1,x9,x9 -> IDEXAin=IDEXBin=00000055, funct7=0100000.
REQ-039 Opcode 1100011 valid -> bubble and illegal=1 for one cycle; the same opcode with flush=1 -> bubble and illegal=0.
REQ-040 exstall held 3 cycles -> ID/EX outputs unchanged throughout; reset_n pulsed low mid-hazard -> all outputs 0 immediately, IFIDstall=0.
